// File: rtl/packed_intc_benes_stream.sv
// rtl/packed_intc_benes_stream.sv - Benes-routed packed interconnect stream with shadowed switch sets
//
// packed_network: pipelined Benes network, one switch set bit per 2x2 switch (1 = cross).
//   clk_i   clock
//   data_i  [0:PORT_NUM-1] input ports
//   sel_i   [0:STAGE_NUM-1][0:SWITCH_NUM-1] switch settings
//   data_o  [0:PORT_NUM-1] routed ports, NET_LAT cycles after data_i
//
// packed_intc_benes_stream: two networks (RAM-to-module, module-to-RAM) fed from one
// accepted beat, with a RUN/DRAIN/SWAP commit protocol for the switch configuration.
//   CLK, RST_N                        clock, synchronous active-low reset
//   I_VALID / O_IN_READY              input beat handshake
//   I_RAM_OUTPUTS, I_MODULE_OUTPUTS   live input ports
//   I_CFG_WE, I_CFG_*_SELECT          shadow configuration write
//   I_CFG_COMMIT, O_CFG_BUSY          shadow-to-active swap request / in progress
//   O_CFG_EPOCH                       completed swap count
//   O_VALID, O_RAM_INPUTS, O_MODULE_INPUTS  routed output beat

module packed_network #(
  parameter int DATA_WIDTH = 256,
  parameter int PORT_NUM   = 32,
  parameter int SWITCH_NUM = PORT_NUM / 2,
  parameter int STAGE_NUM  = 2 * $clog2(PORT_NUM) - 1,
  parameter int NET_LAT    = STAGE_NUM - 1
) (
  input  logic                                 clk_i,
  input  logic [0:PORT_NUM-1][DATA_WIDTH-1:0]  data_i,
  input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] sel_i,
  output logic [0:PORT_NUM-1][DATA_WIDTH-1:0]  data_o
);
  localparam int LOG_N = $clog2(PORT_NUM);

  // bus[s] is the input of stage s; bus[STAGE_NUM] is the network output.
  logic [DATA_WIDTH-1:0] bus [STAGE_NUM+1][PORT_NUM];

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_io
    assign bus[0][p] = data_i[p];
    assign data_o[p] = bus[STAGE_NUM][p];
  end

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    // Butterfly then inverse butterfly: stages pair ports differing in bit
    // LOG_N-1 down to 0, then back up to LOG_N-1 (middle stage shared).
    localparam int BIT = (s < LOG_N) ? (LOG_N - 1 - s) : (s - LOG_N + 1);
    logic [DATA_WIDTH-1:0] sw [PORT_NUM];

    for (genvar k = 0; k < SWITCH_NUM; k++) begin : g_sw
      // Switch k owns the port pair whose index is k with a 0/1 inserted at BIT.
      localparam int LO = ((k >> BIT) << (BIT + 1)) | (k & ((1 << BIT) - 1));
      localparam int HI = LO + (1 << BIT);
      assign sw[LO] = sel_i[s][k] ? bus[s][HI] : bus[s][LO];
      assign sw[HI] = sel_i[s][k] ? bus[s][LO] : bus[s][HI];
    end

    // The first NET_LAT stages are registered; any remaining stages are combinational.
    if (s < NET_LAT) begin : g_reg
      logic [DATA_WIDTH-1:0] pipe_q [PORT_NUM];
      always_ff @(posedge clk_i) pipe_q <= sw;
      for (genvar p = 0; p < PORT_NUM; p++) begin : g_out
        assign bus[s+1][p] = pipe_q[p];
      end
    end else begin : g_comb
      for (genvar p = 0; p < PORT_NUM; p++) begin : g_out
        assign bus[s+1][p] = sw[p];
      end
    end
  end
endmodule

module packed_intc_benes_stream #(
  parameter int DATA_WIDTH = 256,
  parameter int PORT_NUM   = 32,
  parameter int ACTIVE_NUM = 20,
  parameter int SWITCH_NUM = PORT_NUM / 2,
  parameter int STAGE_NUM  = 2 * $clog2(PORT_NUM) - 1,
  parameter int NET_LAT    = STAGE_NUM - 1
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic                                   I_VALID,
  output logic                                   O_IN_READY,
  input  logic [0:ACTIVE_NUM-1][DATA_WIDTH-1:0]  I_RAM_OUTPUTS,
  input  logic [0:ACTIVE_NUM-1][DATA_WIDTH-1:0]  I_MODULE_OUTPUTS,
  input  logic                                   I_CFG_WE,
  input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   I_CFG_MODULE_SELECT,
  input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   I_CFG_SLOT_SELECT,
  input  logic                                   I_CFG_COMMIT,
  output logic                                   O_CFG_BUSY,
  output logic [7:0]                             O_CFG_EPOCH,
  output logic                                   O_VALID,
  output logic [0:ACTIVE_NUM-1][DATA_WIDTH-1:0]  O_RAM_INPUTS,
  output logic [0:ACTIVE_NUM-1][DATA_WIDTH-1:0]  O_MODULE_INPUTS
);
  localparam int VLD_W = NET_LAT + 2;

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

  state_t                               state_q;
  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] shd_mod_q, shd_slot_q, act_mod_q, act_slot_q;
  logic [VLD_W-1:0]                     vld_q, vld_d;
  logic [7:0]                           epoch_q;
  logic                                 o_valid_q;
  logic                                 accept;

  logic [0:ACTIVE_NUM-1][DATA_WIDTH-1:0] ram_in_q, mod_in_q, ram_mid_q, mod_mid_q;
  logic [0:ACTIVE_NUM-1][DATA_WIDTH-1:0] ram_out_q, mod_out_q;
  logic [0:PORT_NUM-1][DATA_WIDTH-1:0]   ram_net_i, mod_net_i, ram_net_o, mod_net_o;

  assign O_IN_READY = (state_q == RUN) & RST_N;
  assign O_CFG_BUSY = (state_q != RUN);
  assign accept     = I_VALID & O_IN_READY;
  // vld_q[0] marks the input register, vld_q[NET_LAT] the network output,
  // vld_q[NET_LAT+1] the mid register feeding the output registers.
  assign vld_d      = {vld_q[VLD_W-2:0], accept};

  assign O_CFG_EPOCH     = epoch_q;
  assign O_VALID         = o_valid_q;
  assign O_RAM_INPUTS    = ram_out_q;
  assign O_MODULE_INPUTS = mod_out_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= RUN;
      shd_mod_q  <= '0;
      shd_slot_q <= '0;
      act_mod_q  <= '0;
      act_slot_q <= '0;
      vld_q      <= '0;
      epoch_q    <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      o_valid_q <= vld_q[VLD_W-1];
      case (state_q)
        RUN: begin
          // A write in the commit cycle lands before the swap reads the shadow.
          if (I_CFG_WE) begin
            shd_mod_q  <= I_CFG_MODULE_SELECT;
            shd_slot_q <= I_CFG_SLOT_SELECT;
          end
          if (I_CFG_COMMIT) state_q <= DRAIN;
        end
        DRAIN: if (vld_q == '0) state_q <= SWAP;
        SWAP: begin
          act_mod_q  <= shd_mod_q;
          act_slot_q <= shd_slot_q;
          epoch_q    <= epoch_q + 8'd1;
          state_q    <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    ram_net_i = '0;
    mod_net_i = '0;
    ram_net_i[0:ACTIVE_NUM-1] = ram_in_q;
    mod_net_i[0:ACTIVE_NUM-1] = mod_in_q;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      ram_in_q <= I_RAM_OUTPUTS;
      mod_in_q <= I_MODULE_OUTPUTS;
    end
    if (vld_q[VLD_W-2]) begin
      ram_mid_q <= ram_net_o[0:ACTIVE_NUM-1];
      mod_mid_q <= mod_net_o[0:ACTIVE_NUM-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ram_out_q <= '0;
      mod_out_q <= '0;
    end else if (vld_q[VLD_W-1]) begin
      ram_out_q <= ram_mid_q;
      mod_out_q <= mod_mid_q;
    end
  end

  packed_network #(
    .DATA_WIDTH(DATA_WIDTH), .PORT_NUM(PORT_NUM), .SWITCH_NUM(SWITCH_NUM),
    .STAGE_NUM(STAGE_NUM), .NET_LAT(NET_LAT)
  ) u_ram_net (
    .clk_i(CLK), .data_i(ram_net_i), .sel_i(act_mod_q), .data_o(ram_net_o)
  );

  packed_network #(
    .DATA_WIDTH(DATA_WIDTH), .PORT_NUM(PORT_NUM), .SWITCH_NUM(SWITCH_NUM),
    .STAGE_NUM(STAGE_NUM), .NET_LAT(NET_LAT)
  ) u_mod_net (
    .clk_i(CLK), .data_i(mod_net_i), .sel_i(act_slot_q), .data_o(mod_net_o)
  );

  // Dummy network outputs are discarded.
  if (ACTIVE_NUM < PORT_NUM) begin : g_dummy
    logic unused_dummy;
    assign unused_dummy = ^{ram_net_o[ACTIVE_NUM:PORT_NUM-1], mod_net_o[ACTIVE_NUM:PORT_NUM-1]};
  end
endmodule

// File: tb/tb_packed_intc_benes_stream.sv
// tb/tb_packed_intc_benes_stream.sv - scoreboard bench for packed_intc_benes_stream
`timescale 1ns/1ps
module tb_packed_intc_benes_stream;
  localparam int DW   = 256;
  localparam int PN   = 32;
  localparam int AN   = 20;
  localparam int LOGN = $clog2(PN);
  localparam int SN   = 2 * LOGN - 1;
  localparam int SWN  = PN / 2;

  typedef logic [0:AN-1][DW-1:0] vec_t;
  typedef logic [0:SN-1][0:SWN-1] sel_t;
  typedef struct { vec_t ram; vec_t mod; } exp_t;

  logic CLK = 1'b0;
  logic RST_N, I_VALID, O_IN_READY, I_CFG_WE, I_CFG_COMMIT, O_CFG_BUSY, O_VALID;
  vec_t I_RAM_OUTPUTS, I_MODULE_OUTPUTS, O_RAM_INPUTS, O_MODULE_INPUTS;
  sel_t I_CFG_MODULE_SELECT, I_CFG_SLOT_SELECT;
  logic [7:0] O_CFG_EPOCH;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  int act_mod_kind = 0, act_slot_kind = 0, shd_mod_kind = 0, shd_slot_kind = 0;
  logic [7:0] exp_epoch = 8'd0;
  int cur_run = 0, max_run = 0;

  packed_intc_benes_stream dut (
    .CLK(CLK), .RST_N(RST_N), .I_VALID(I_VALID), .O_IN_READY(O_IN_READY),
    .I_RAM_OUTPUTS(I_RAM_OUTPUTS), .I_MODULE_OUTPUTS(I_MODULE_OUTPUTS),
    .I_CFG_WE(I_CFG_WE), .I_CFG_MODULE_SELECT(I_CFG_MODULE_SELECT),
    .I_CFG_SLOT_SELECT(I_CFG_SLOT_SELECT), .I_CFG_COMMIT(I_CFG_COMMIT),
    .O_CFG_BUSY(O_CFG_BUSY), .O_CFG_EPOCH(O_CFG_EPOCH), .O_VALID(O_VALID),
    .O_RAM_INPUTS(O_RAM_INPUTS), .O_MODULE_INPUTS(O_MODULE_INPUTS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Permutation kinds: 0 identity, 1 full reversal, 2 xor MSB, 3 xor LSB.
  function automatic int src_of(input int kind, input int j);
    case (kind)
      1:       return PN - 1 - j;
      2:       return j ^ (PN / 2);
      3:       return j ^ 1;
      default: return j;
    endcase
  endfunction

  function automatic vec_t route(input vec_t v, input int kind);
    vec_t r;
    for (int j = 0; j < AN; j++) begin
      int s;
      s = src_of(kind, j);
      r[j] = (s < AN) ? v[s] : '0;
    end
    return r;
  endfunction

  // Crossing every switch of a stage xors the port index with that stage's pair bit.
  function automatic sel_t cfg_of(input int kind);
    sel_t c;
    c = '0;
    case (kind)
      1: for (int s = 0; s < LOGN; s++) c[s] = '1;
      2: c[0] = '1;
      3: c[LOGN-1] = '1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < AN; j++)
      for (int w = 0; w < DW / 32; w++) v[j][w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic drive_beat(input vec_t r, input vec_t m);
    check("ready_at_send", O_IN_READY, 1);
    I_VALID = 1'b1;
    I_RAM_OUTPUTS = r;
    I_MODULE_OUTPUTS = m;
    sb.push_back('{ram: route(r, act_mod_kind), mod: route(m, act_slot_kind)});
    @(negedge CLK);
    I_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("scoreboard_drained", (sb.size() == 0), 1);
  endtask

  task automatic do_commit(input bit we, input int mk, input int sk, output int lows);
    I_CFG_WE = we;
    I_CFG_COMMIT = 1'b1;
    I_CFG_MODULE_SELECT = cfg_of(mk);
    I_CFG_SLOT_SELECT = cfg_of(sk);
    if (we) begin
      shd_mod_kind = mk;
      shd_slot_kind = sk;
    end
    @(negedge CLK);
    I_CFG_WE = 1'b0;
    I_CFG_COMMIT = 1'b0;
    lows = 0;
    while (!O_IN_READY && lows < 60) begin
      lows++;
      @(negedge CLK);
    end
    check("commit_completes", O_IN_READY, 1);
    act_mod_kind = shd_mod_kind;
    act_slot_kind = shd_slot_kind;
    exp_epoch = exp_epoch + 8'd1;
    check("epoch_after_commit", O_CFG_EPOCH, exp_epoch);
  endtask

  always @(negedge CLK) begin
    if (RST_N && O_VALID) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (sb.size() == 0) begin
        check("unexpected_valid", O_VALID, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int j = 0; j < AN; j++) begin
          check($sformatf("ram_port%0d", j), O_RAM_INPUTS[j], e.ram[j]);
          check($sformatf("mod_port%0d", j), O_MODULE_INPUTS[j], e.mod[j]);
        end
      end
    end else begin
      cur_run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r, m;
    int lows, lat, vcount;
    RST_N = 1'b0;
    I_VALID = 1'b0;
    I_CFG_WE = 1'b0;
    I_CFG_COMMIT = 1'b0;
    I_RAM_OUTPUTS = '0;
    I_MODULE_OUTPUTS = '0;
    I_CFG_MODULE_SELECT = '0;
    I_CFG_SLOT_SELECT = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_in_ready", O_IN_READY, 0);
    check("rst_valid", O_VALID, 0);
    check("rst_epoch", O_CFG_EPOCH, 0);
    check("rst_busy", O_CFG_BUSY, 0);
    check("rst_ram_out_zero", (O_RAM_INPUTS == '0), 1);
    check("rst_mod_out_zero", (O_MODULE_INPUTS == '0), 1);
    RST_N = 1'b1;
    #1;
    check("ready_after_release", O_IN_READY, 1);
    @(negedge CLK);

    // Identity commit, one beat with port j = j+1, latency 10
    do_commit(1'b1, 0, 0, lows);
    check("identity_commit_lows", lows, 2);
    for (int j = 0; j < AN; j++) begin
      r[j] = DW'(j + 1);
      m[j] = DW'(j + 1);
    end
    drive_beat(r, m);
    lat = 0;
    while (!O_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("latency", lat, 10);
    @(negedge CLK);
    check("single_valid_pulse", O_VALID, 0);
    wait_drain();

    // 16 back-to-back beats
    max_run = 0;
    for (int b = 0; b < 16; b++) drive_beat(rand_vec(), rand_vec());
    wait_drain();
    repeat (2) @(negedge CLK);
    check("back_to_back_run", max_run, 16);

    // Reversal commit in the cycle of the third in-flight beat
    drive_beat(rand_vec(), rand_vec());
    drive_beat(rand_vec(), rand_vec());
    I_CFG_WE = 1'b1;
    I_CFG_COMMIT = 1'b1;
    I_CFG_MODULE_SELECT = cfg_of(1);
    I_CFG_SLOT_SELECT = cfg_of(1);
    shd_mod_kind = 1;
    shd_slot_kind = 1;
    drive_beat(rand_vec(), rand_vec());
    I_CFG_WE = 1'b0;
    I_CFG_COMMIT = 1'b0;
    check("ready_low_after_commit", O_IN_READY, 0);
    check("busy_after_commit", O_CFG_BUSY, 1);
    // Writes and commits during DRAIN are ignored
    I_CFG_WE = 1'b1;
    I_CFG_COMMIT = 1'b1;
    I_CFG_MODULE_SELECT = cfg_of(2);
    I_CFG_SLOT_SELECT = cfg_of(2);
    @(negedge CLK);
    I_CFG_WE = 1'b0;
    I_CFG_COMMIT = 1'b0;
    lows = 2;
    while (!O_IN_READY && lows < 60) begin
      lows++;
      @(negedge CLK);
    end
    check("reversal_commit_completes", O_IN_READY, 1);
    check("in_flight_drained", (sb.size() == 0), 1);
    act_mod_kind = 1;
    act_slot_kind = 1;
    exp_epoch = exp_epoch + 8'd1;
    check("epoch_after_reversal", O_CFG_EPOCH, exp_epoch);
    @(negedge CLK);
    check("no_stray_commit", O_IN_READY, 1);
    drive_beat(rand_vec(), rand_vec());
    wait_drain();

    // Write and commit in the same cycle, empty pipeline
    do_commit(1'b1, 2, 3, lows);
    check("we_commit_lows", lows, 2);
    drive_beat(rand_vec(), rand_vec());
    wait_drain();

    // Commit without a write keeps the shadow and still bumps the epoch
    do_commit(1'b0, 0, 0, lows);
    check("nowrite_commit_lows", lows, 2);
    drive_beat(rand_vec(), rand_vec());
    wait_drain();

    // Epoch wraps 255 -> 0
    while (exp_epoch != 8'd0) do_commit(1'b0, 0, 0, lows);
    check("epoch_wrapped", O_CFG_EPOCH, 0);

    // Reset during DRAIN with 2 beats in flight
    drive_beat(rand_vec(), rand_vec());
    drive_beat(rand_vec(), rand_vec());
    I_CFG_WE = 1'b1;
    I_CFG_COMMIT = 1'b1;
    I_CFG_MODULE_SELECT = cfg_of(1);
    I_CFG_SLOT_SELECT = cfg_of(1);
    @(negedge CLK);
    I_CFG_WE = 1'b0;
    I_CFG_COMMIT = 1'b0;
    check("drain_busy", O_CFG_BUSY, 1);
    RST_N = 1'b0;
    sb.delete();
    repeat (2) @(negedge CLK);
    check("mid_rst_in_ready", O_IN_READY, 0);
    RST_N = 1'b1;
    act_mod_kind = 0;
    act_slot_kind = 0;
    shd_mod_kind = 0;
    shd_slot_kind = 0;
    exp_epoch = 8'd0;
    vcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (O_VALID) vcount++;
    end
    check("no_valid_after_reset", vcount, 0);
    check("epoch_after_reset", O_CFG_EPOCH, 0);
    drive_beat(rand_vec(), rand_vec());
    wait_drain();

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
